// File: rtl/i2c_csr_fifo.sv
// rtl/i2c_csr_fifo.sv - I2C master CSR block with TX command and RX data FIFOs
// Optional bus-hang timeout counter: define I2C_CSR_FIFO_TIMEOUT_EN.
module i2c_csr_fifo #(
  parameter int ADD_WIDTH  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [ADD_WIDTH-1:0] addr,
  input  logic [31:0]          wdata,
  input  logic                 wren,
  input  logic                 rden,
  output logic [31:0]          rdata,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_data,
  output logic                 cmd_start,
  output logic                 cmd_stop,
  output logic                 cmd_read,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 core_busy,
  input  logic                 core_nack,
  input  logic                 core_arb_lost,
  output logic                 core_abort,
  output logic                 core_enable,
  output logic [6:0]           slave_addr,
  output logic [DIV_WIDTH-1:0] clk_div,
  output logic                 interrupt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [5:0]    word;
  logic          en;
  logic [6:0]    int_stat;
  logic [6:0]    int_en;
  logic [6:0]    int_view;
  logic [6:0]    int_set;
  logic [6:0]    int_clr;
  logic [31:0]   rd_mux;
  logic          flush_wr;
  logic          to_hit;
  logic [15:0]   timeout_view;
  logic          unused_bits;

  logic [10:0]   tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_count, tx_count_nxt;
  logic          tx_full, tx_empty, tx_wr, tx_push, tx_pop, tx_ovf, tx_empty_evt;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_count, rx_count_nxt;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_ovf;

  assign word        = addr[7:2];
  assign unused_bits = ^{addr[1:0], wdata[31:11]};
  assign flush_wr    = wren && (word == 6'd0) && wdata[1];
  assign core_enable = en;

  assign tx_full   = (tx_count == CW'(FIFO_DEPTH));
  assign tx_empty  = (tx_count == '0);
  assign tx_wr     = wren && (word == 6'd2);
  assign tx_push   = tx_wr && !tx_full;
  assign tx_ovf    = tx_wr && tx_full;
  assign cmd_valid = en && !tx_empty;
  assign tx_pop    = cmd_valid && cmd_ready;
  assign cmd_data  = tx_mem[tx_rp][7:0];
  assign cmd_start = tx_mem[tx_rp][8];
  assign cmd_stop  = tx_mem[tx_rp][9];
  assign cmd_read  = tx_mem[tx_rp][10];

  assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign rx_pop   = rden && (word == 6'd3) && !rx_empty;
  // A pop frees the slot the same-cycle push lands in, so a full FIFO can still accept.
  assign rx_push  = rx_valid && (!rx_full || rx_pop);
  assign rx_ovf   = rx_valid && rx_full && !rx_pop;

  // Next FIFO occupancy; flush wins over any push or pop in the write cycle.
  always_comb begin
    tx_count_nxt = tx_count;
    rx_count_nxt = rx_count;
    if (flush_wr) begin
      tx_count_nxt = '0;
      rx_count_nxt = '0;
    end else begin
      if (tx_push && !tx_pop)      tx_count_nxt = tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count_nxt = tx_count - 1'b1;
      if (rx_push && !rx_pop)      rx_count_nxt = rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count_nxt = rx_count - 1'b1;
    end
  end

  assign tx_empty_evt = (tx_count == CW'(1)) && (tx_count_nxt == '0);

  // Interrupt status view: RX_AVAIL is a live level, never stored.
  assign int_view = {int_stat[6], ~rx_empty, int_stat[4:0]};
  assign int_set  = {to_hit, 1'b0, tx_empty_evt, core_arb_lost, core_nack, rx_ovf, tx_ovf};
  assign int_clr  = (wren && (word == 6'd6)) ? wdata[6:0] : 7'h00;

`ifdef I2C_CSR_FIFO_TIMEOUT_EN
  logic [15:0] timeout_reg;
  logic [15:0] to_cnt;

  // Timeout fires on the busy cycle where the count would reach the limit.
  always_comb begin
    to_hit = en && core_busy && (timeout_reg != 16'h0) && ((to_cnt + 16'd1) == timeout_reg);
  end

  // Timeout limit register and busy-cycle counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      timeout_reg <= 16'hFFFF;
      to_cnt      <= 16'h0;
    end else begin
      if (wren && (word == 6'd9)) timeout_reg <= wdata[15:0];
      if (!core_busy || !en || (timeout_reg == 16'h0) || to_hit) to_cnt <= 16'h0;
      else                                                     to_cnt <= to_cnt + 16'd1;
    end
  end

  assign timeout_view = timeout_reg;
`else
  assign to_hit       = 1'b0;
  assign timeout_view = 16'h0;
`endif

  // Read-data mux; unmapped words read zero.
  always_comb begin
    rd_mux = 32'h0;
    case (word)
      6'd0: rd_mux[0]   = en;
      6'd1: rd_mux[4:0] = {rx_empty, rx_full, tx_empty, tx_full, core_busy};
      6'd3: rd_mux[8:0] = rx_empty ? 9'h000 : {1'b1, rx_mem[rx_rp]};
      6'd4: rd_mux[6:0] = slave_addr;
      6'd5: rd_mux[DIV_WIDTH-1:0] = clk_div;
      6'd6: rd_mux[6:0] = int_view;
      6'd7: rd_mux[6:0] = int_en;
      6'd8: rd_mux[15:0] = {8'(rx_count), 8'(tx_count)};
      6'd9: rd_mux[15:0] = timeout_view;
      default: rd_mux = 32'h0;
    endcase
  end

  // FIFO storage, not reset: contents are meaningless while the counts are zero.
  always_ff @(posedge aclk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata[10:0];
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  // Control registers, FIFO pointers, read data and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en         <= 1'b0;
      slave_addr <= 7'h00;
      clk_div    <= DIV_WIDTH'(100);
      int_en     <= 7'h00;
      int_stat   <= 7'h00;
      rdata      <= 32'h0;
      core_abort <= 1'b0;
      interrupt  <= 1'b0;
      tx_wp      <= '0;
      tx_rp      <= '0;
      tx_count   <= '0;
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_count   <= '0;
    end else begin
      if (wren && (word == 6'd0)) en         <= wdata[0];
      if (wren && (word == 6'd4)) slave_addr <= wdata[6:0];
      if (wren && (word == 6'd5)) clk_div    <= wdata[DIV_WIDTH-1:0];
      if (wren && (word == 6'd7)) int_en     <= wdata[6:0];
      int_stat   <= ((int_stat & ~int_clr) | int_set) & 7'h5F;
      interrupt  <= |(int_view & int_en);
      core_abort <= flush_wr || to_hit;
      if (rden) rdata <= rd_mux;
      tx_count <= tx_count_nxt;
      rx_count <= rx_count_nxt;
      if (flush_wr) begin
        tx_wp <= '0;
        tx_rp <= '0;
        rx_wp <= '0;
        rx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + 1'b1;
        if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        if (rx_push) rx_wp <= rx_wp + 1'b1;
        if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
    end
  end

endmodule

// File: doc/i2c_csr_fifo.md
I2C_CSR_FIFO -- requirements
Module: i2c_csr_fifo

Interface
REQ-001 Parameters:
- ADD_WIDTH, default 8, CSR address width.
- FIFO_DEPTH, default 8, TX and RX FIFO entries; power of 2, minimum 2.
- DIV_WIDTH, default 16, clock divider width.

REQ-002 Ports, one per line (name, direction, width, meaning). Single clock aclk; reset aresetn is asynchronous and active-low.
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- addr  in  ADD_WIDTH  CSR byte address; word index is addr[7:2].
- wdata  in  32  write data.
- wren  in  1  write strobe, one cycle per access.
- rden  in  1  read strobe, one cycle per access.
- rdata  out  32  read data, registered.
- cmd_valid  out  1  TX command available to the core.
- cmd_ready  in  1  core accepts the command.
- cmd_data  out  8  command byte.
- cmd_start  out  1  generate START before this byte.
- cmd_stop  out  1  generate STOP after this byte.
- cmd_read  out  1  this command is a read.
- rx_valid  in  1  one-cycle received-byte pulse.
- rx_data  in  8  received byte.
- core_busy  in  1  core transaction active.
- core_nack  in  1  one-cycle NACK pulse.
- core_arb_lost  in  1  one-cycle arbitration-lost pulse.
- core_abort  out  1  one-cycle abort request to the core.
- core_enable  out  1  CTRL.EN.
- slave_addr  out  7  target address.
- clk_div  out  DIV_WIDTH  SCL divider.
- interrupt  out  1  level interrupt.

Function
REQ-003 Register map (word index):
- 0 CTRL: bit0 EN, bit1 FLUSH (self-clearing, reads 0).
- 1 STATUS (RO): bit0 busy, bit1 tx_full, bit2 tx_empty, bit3 rx_full, bit4 rx_empty.
- 2 TXQ (WO): push {wdata[10] read, [9] stop, [8] start, [7:0] data}.
- 3 RXQ (RO): pop; rdata[7:0] = byte, rdata[8] = 1 when the entry was valid.
- 4 ADDR: [6:0].
- 5 CLKDIV: [DIV_WIDTH-1:0].
- 6 INT_STAT (W1C).
- 7 INT_EN.
- 8 LEVEL (RO): [15:8] rx_count, [7:0] tx_count.
- 9 TIMEOUT.
- Unmapped reads return 0; unmapped writes are ignored.

REQ-004 Read latency: rdata is valid the cycle after rden and holds until the next rden.

REQ-005 FIFOs are first-word-fall-through with counts 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

REQ-006 cmd_valid = EN && !tx_empty. cmd_* fields are driven from the TX head. The TX FIFO pops on cmd_valid && cmd_ready.

REQ-007 A TXQ write while tx_full drops the data, leaves the count unchanged, and sets INT_STAT bit0 TX_OVF.

REQ-008 rx_valid while rx_full drops the byte and sets INT_STAT bit1 RX_OVF. An RXQ read when rx_empty returns 0 and changes nothing.

REQ-009 Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged. On an empty TX FIFO a same-cycle push does not pop. A same-cycle RX push and pop on a full RX FIFO succeeds with no overflow.

REQ-010 INT_STAT sources:
- bit2 NACK, set by core_nack.
- bit3 ARB, set by core_arb_lost.
- bit4 TX_EMPTY, set on the tx_count transition 1->0.
- bit5 RX_AVAIL, level equal to !rx_empty; not writable.
- bit6 TIMEOUT.

REQ-011 A set event in the same cycle as a W1C to that bit leaves the bit set.

REQ-012 interrupt = |(INT_STAT & INT_EN), registered, one cycle after the status change.

REQ-013 FLUSH empties both FIFOs in the cycle after the write, overriding any same-cycle push or pop. It pulses core_abort for one cycle.

REQ-014 core_enable = CTRL.EN. When EN = 0, cmd_valid = 0 and the FIFOs keep their contents.

Reset
REQ-015 On aresetn low, asynchronously:
- CTRL, ADDR, INT_STAT, INT_EN, rdata, all pointers and counts = 0.
- CLKDIV = 100; TIMEOUT = 0xFFFF.
- Outputs: cmd_valid 0, core_abort 0, interrupt 0.

REQ-016 Reset asserted mid-transaction discards FIFO contents. There is no partial-state recovery.

Configuration
REQ-017 Macro I2C_CSR_FIFO_TIMEOUT_EN.
- Defined: a 16-bit counter increments each cycle while core_busy && EN, and clears when core_busy = 0.
- On reaching the TIMEOUT register value (nonzero), it sets INT_STAT bit6, pulses core_abort for one cycle, and clears.
- TIMEOUT = 0 disables the counter.
- Not defined: no counter; word 9 reads 0 and writes are ignored; INT_STAT bit6 is tied to 0.

Verification
REQ-018 Write TXQ 0x1A5 (start, data A5); cmd_ready held 1 -> cmd_valid rises next cycle with cmd_data 0xA5, cmd_start 1; tx_count returns to 0; INT_STAT bit4 sets.

REQ-019 Push 9 entries with EN = 0, FIFO_DEPTH 8 -> LEVEL tx_count = 8, INT_STAT bit0 = 1, first 8 data are preserved in order.

REQ-020 Pulse rx_valid with 0x3C, then read RXQ -> rdata = 0x13C the next cycle; a second read -> rdata = 0; RX_AVAIL falls.

REQ-021 INT_EN = 0x04, pulse core_nack -> interrupt = 1 one cycle later; W1C 0x04 -> interrupt = 0; W1C in the same cycle as core_nack -> bit stays 1.

REQ-022 TIMEOUT_EN defined, TIMEOUT = 10, core_busy held 1 -> core_abort pulses on busy cycle 10 and INT_STAT bit6 sets; with TIMEOUT = 0 -> no abort.

REQ-023 3 entries in TX, write CTRL = 0x3 while cmd_ready = 1 -> both counts = 0 next cycle, core_abort pulses once, CTRL reads 0x1.
